// File: rtl/alu_cmd_driver_if.sv
// Command channel from instruction decode (master) into alu_cmd_driver (slave).
interface alu_cmd_driver_if;
    localparam int unsigned AW  = 3;
    localparam int unsigned OPW = 3;
    localparam int unsigned DW  = 16;

    logic           cmd_valid;
    logic           cmd_ready;
    logic [OPW-1:0] cmd_op;
    logic [AW-1:0]  cmd_dst;
    logic [AW-1:0]  cmd_src1;
    logic [AW-1:0]  cmd_src2;
    logic           cmd_imm_en;
    logic [DW-1:0]  cmd_imm;

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src1, cmd_src2, cmd_imm_en, cmd_imm,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src1, cmd_src2, cmd_imm_en, cmd_imm,
        output cmd_ready
    );
endinterface

// File: rtl/alu_cmd_driver.sv
// Sequences register-level commands onto a combinational 16-bit ALU and writes results back.
// Optional: define ALU_CMD_DRIVER_ILLEGAL_TRAP_EN to trap op codes 001/010/011 via cmd_err.
module alu_cmd_driver #(
    localparam int unsigned NREGS = 8,
    localparam int unsigned AW    = 3,
    localparam int unsigned OPW   = 3,
    localparam int unsigned DW    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_cmd_driver_if.slave cmd,
    output logic [DW-1:0]   alu_operand1,
    output logic [DW-1:0]   alu_operand2,
    output logic [OPW-1:0]  alu_operation,
    input  logic [DW-1:0]   alu_result,
    output logic            wb_valid,
    output logic [AW-1:0]   wb_dst,
    output logic [DW-1:0]   wb_data,
    input  logic [AW-1:0]   dbg_addr,
    output logic [DW-1:0]   dbg_data,
    output logic            cmd_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   rf_q [NREGS];
    logic [DW-1:0]   rf_d [NREGS];
    logic [DW-1:0]   op1_q, op1_d;
    logic [DW-1:0]   op2_q, op2_d;
    logic [OPW-1:0]  opc_q, opc_d;
    logic [AW-1:0]   dst_q, dst_d;
    logic            wb_valid_q, wb_valid_d;
    logic [AW-1:0]   wb_dst_q, wb_dst_d;
    logic [DW-1:0]   wb_data_q, wb_data_d;
    logic            err_q, err_d;
    logic            accept;
    logic            trap;

    // Ready is decoded from the state flop and forced low while reset is asserted.
    assign cmd.cmd_ready = rst_n && (state_q == IDLE);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

`ifdef ALU_CMD_DRIVER_ILLEGAL_TRAP_EN
    assign trap = accept && (cmd.cmd_op inside {3'b001, 3'b010, 3'b011});
`else
    assign trap = 1'b0;
`endif

    // Next-state and datapath: sources are read at accept, the write lands at the end of ISSUE.
    always_comb begin
        state_d    = state_q;
        rf_d       = rf_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        opc_d      = opc_q;
        dst_d      = dst_q;
        wb_valid_d = 1'b0;
        wb_dst_d   = wb_dst_q;
        wb_data_d  = wb_data_q;
        err_d      = trap;

        case (state_q)
            IDLE: begin
                if (accept && !trap) begin
                    op1_d   = rf_q[cmd.cmd_src1];
                    op2_d   = cmd.cmd_imm_en ? cmd.cmd_imm : rf_q[cmd.cmd_src2];
                    opc_d   = cmd.cmd_op;
                    dst_d   = cmd.cmd_dst;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                rf_d[dst_q] = alu_result;
                wb_valid_d  = 1'b1;
                wb_dst_d    = dst_q;
                wb_data_d   = alu_result;
                state_d     = WB;
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rf_q       <= '{default: '0};
            op1_q      <= '0;
            op2_q      <= '0;
            opc_q      <= '0;
            dst_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_dst_q   <= '0;
            wb_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rf_q       <= rf_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            opc_q      <= opc_d;
            dst_q      <= dst_d;
            wb_valid_q <= wb_valid_d;
            wb_dst_q   <= wb_dst_d;
            wb_data_q  <= wb_data_d;
            err_q      <= err_d;
        end
    end

    assign alu_operand1  = op1_q;
    assign alu_operand2  = op2_q;
    assign alu_operation = opc_q;
    assign wb_valid      = wb_valid_q;
    assign wb_dst        = wb_dst_q;
    assign wb_data       = wb_data_q;
    assign cmd_err       = err_q;
    assign dbg_data      = rf_q[dbg_addr];

endmodule
